// File: rtl/ctrl_decode_pipe.sv
// ID-stage decoder feeding a registered ID/EX control bundle, plus a HI/LO mult/div sequencer.
// Optional feature: define CTRL_ILLEGAL_OP_EN to flag undefined encodings through ex_illegal.
module ctrl_decode_pipe #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int ALUOP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               id_stall,
  input  logic               id_flush,
  output logic               id_jump,
  output logic [1:0]         id_pc_source,
  output logic               stall_req,
  output logic               md_busy,
  output logic               md_done,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_alu_src_a,
  output logic               ex_alu_src_b,
  output logic               ex_ext_op,
  output logic               ex_lui_op,
  output logic [1:0]         ex_reg_dst,
  output logic [1:0]         ex_mem_to_reg,
  output logic [2:0]         ex_branch,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [1:0]         ex_md_op,
  output logic               ex_md_signed,
  output logic [1:0]         ex_hilo_write,
  output logic               ex_illegal
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src_a;
    logic               alu_src_b;
    logic               ext_op;
    logic               lui_op;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic [2:0]         branch;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         md_op;
    logic               md_signed;
    logic [1:0]         hilo_write;
    logic               illegal;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  ctrl_t      dec, ex_d, ex_q;
  md_state_e  state_d, state_q;
  logic [5:0] cnt_d, cnt_q;
  logic       md_done_d, md_done_q;
  logic       is_r, is_j, is_jr, hilo_dep, md_last, accept;

  assign is_r     = (opcode == 6'h00);
  assign is_j     = (opcode == 6'h02) || (opcode == 6'h03);
  assign is_jr    = is_r && ((funct == 6'h08) || (funct == 6'h09));
  assign hilo_dep = is_r && (funct inside {6'h10, 6'h11, 6'h12, 6'h13,
                                           6'h18, 6'h19, 6'h1a, 6'h1b});

  assign id_jump      = id_valid && (is_j || is_jr);
  assign id_pc_source = !id_valid ? 2'b00 : is_j ? 2'b01 : is_jr ? 2'b10 : 2'b00;

  assign md_busy   = (state_q != IDLE);
  assign md_done   = md_done_q;
  assign md_last   = md_busy && (cnt_q == 6'd0);
  assign stall_req = id_valid && hilo_dep && md_busy && !md_last;
  assign accept    = id_valid && !id_flush && !id_stall && !stall_req;

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.alu_op = ALUOP_W'(2);
    case (opcode)
      6'h00: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'b01;
        case (funct)
          6'h00, 6'h02, 6'h03: dec.alu_src_a = 1'b1;
          6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: ;
          6'h08: dec.reg_write = 1'b0;
          6'h09: dec.mem_to_reg = 2'b10;
          6'h11: begin dec.reg_write = 1'b0; dec.hilo_write = 2'b10; end
          6'h13: begin dec.reg_write = 1'b0; dec.hilo_write = 2'b01; end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            dec.reg_write = 1'b0;
            dec.alu_op    = ALUOP_W'(7);
            dec.md_op     = funct[1] ? 2'b10 : 2'b01;
            dec.md_signed = !funct[0];
          end
          default: begin
`ifdef CTRL_ILLEGAL_OP_EN
            dec.illegal = 1'b1;
`endif
          end
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        dec.alu_op = ALUOP_W'(1);
        dec.ext_op = 1'b1;
        dec.branch = (opcode == 6'h01) ? 3'd5 : 3'(opcode[2:0] - 3'd3);
      end
      6'h02: dec.alu_op = '0;
      6'h03: begin
        dec.reg_write  = 1'b1;
        dec.reg_dst    = 2'b10;
        dec.mem_to_reg = 2'b10;
        dec.alu_op     = '0;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.ext_op    = 1'b1;
        dec.alu_op    = opcode[1] ? ALUOP_W'(4) : '0;
      end
      6'h0c, 6'h0d, 6'h0e: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = (opcode == 6'h0c) ? ALUOP_W'(3) :
                        (opcode == 6'h0d) ? ALUOP_W'(5) : ALUOP_W'(6);
      end
      6'h0f: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.lui_op    = 1'b1;
        dec.alu_op    = '0;
      end
      6'h23: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.ext_op     = 1'b1;
        dec.mem_to_reg = 2'b01;
        dec.alu_op     = '0;
      end
      6'h2b: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.ext_op    = 1'b1;
        dec.alu_op    = '0;
      end
      default: begin
        dec.reg_write = 1'b1;
`ifdef CTRL_ILLEGAL_OP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
    // An undefined encoding still occupies the EX slot but must not change any state.
`ifdef CTRL_ILLEGAL_OP_EN
    if (dec.illegal) begin
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.md_op      = 2'b00;
      dec.md_signed  = 1'b0;
      dec.hilo_write = 2'b00;
    end
`else
    dec.illegal = 1'b0;
`endif
  end

  always_comb begin
    ex_d = ex_q;
    if (id_flush)       ex_d = '0;
    else if (id_stall)  ex_d = ex_q;
    else if (stall_req) ex_d = '0;
    else if (id_valid)  ex_d = dec;
    else                ex_d = '0;
  end

  // The sequencer runs independently of pipeline stalls; only an accepted md op reloads it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != IDLE) begin
      if (cnt_q == 6'd0) state_d = IDLE;
      else               cnt_d   = cnt_q - 6'd1;
    end
    if (accept && dec.md_op == 2'b01) begin
      state_d = MUL;
      cnt_d   = MUL_LOAD;
    end else if (accept && dec.md_op == 2'b10) begin
      state_d = DIV;
      cnt_d   = DIV_LOAD;
    end
    md_done_d = (state_d != IDLE) && (cnt_d == 6'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      md_done_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src_a  = ex_q.alu_src_a;
  assign ex_alu_src_b  = ex_q.alu_src_b;
  assign ex_ext_op     = ex_q.ext_op;
  assign ex_lui_op     = ex_q.lui_op;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_branch     = ex_q.branch;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_md_op      = ex_q.md_op;
  assign ex_md_signed  = ex_q.md_signed;
  assign ex_hilo_write = ex_q.hilo_write;
  assign ex_illegal    = ex_q.illegal;

endmodule
